// File: rtl/dct_mac_pkg.sv
// dct_mac_pkg: shared constants and helpers for the DCT multiply-accumulate path.
//   Def*       default widths for the forward-DCT instance (8-bit samples, Q1.14 coefficients).
//   tap_width  width of a tap counter for a given number of taps.
//   acc_w_ok   checks that an accumulator width cannot overflow and is in range for the helpers.
//   round_half_up / sat_clip  fixed-point output conversion, evaluated on 64-bit values.
package dct_mac_pkg;

   localparam int unsigned DefDataW  = 8;
   localparam int unsigned DefCoefW  = 16;
   localparam int unsigned DefAccW   = 32;
   localparam int unsigned DefNTaps  = 8;
   localparam int unsigned DefFracSh = 14;
   localparam int unsigned DefOutW   = 12;

   function automatic int unsigned tap_width(input int unsigned n_taps);
      return (n_taps < 2) ? 1 : $clog2(n_taps);
   endfunction

   // Helpers below work on 64-bit values, so the accumulator must fit in 64 bits.
   function automatic bit acc_w_ok(input int unsigned acc_w, input int unsigned data_w,
                                   input int unsigned coef_w, input int unsigned n_taps);
      return (acc_w >= data_w + coef_w + $clog2(n_taps)) && (acc_w <= 64);
   endfunction

   // Adds one half LSB of the result, then shifts arithmetically: ties round toward +inf.
   function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                        input int unsigned sh);
      return (v + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction

   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                   input int unsigned out_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (v > max_v) return max_v;
      if (v < min_v) return min_v;
      return v;
   endfunction

endpackage

// File: rtl/dct_mac_round_sat.sv
// dct_mac_round_sat: combinational accumulator-to-result conversion.
//   acc     signed accumulator value (ACC_W bits)
//   result  acc scaled down by 2^FRAC_SH, rounded half up, saturated to OUT_W signed bits
//   sat     high when the rounded value had to be clipped
module dct_mac_round_sat
   import dct_mac_pkg::*;
#(
   parameter int unsigned ACC_W   = DefAccW,
   parameter int unsigned FRAC_SH = DefFracSh,
   parameter int unsigned OUT_W   = DefOutW
) (
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] result,
   output logic             sat
);

   logic signed [63:0] acc_ext;
   logic signed [63:0] rounded;
   logic signed [63:0] clipped;

   always_comb begin
      acc_ext = 64'($signed(acc));
      rounded = round_half_up(acc_ext, FRAC_SH);
      clipped = sat_clip(rounded, OUT_W);
      result  = OUT_W'(clipped);
      sat     = (clipped != rounded);
   end

endmodule

// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: pipelined signed multiply-accumulate for the forward DCT.
//   clk, rst                  clock, synchronous active-high reset
//   clear                     abort the current group and any in-flight products
//   in_valid/in_ready         sample/coefficient beat handshake
//   in_sample, in_coef        signed operands
//   out_valid/out_ready       result handshake with backpressure
//   out_result, out_sat       rounded, saturated result and clip flag
//   tap_idx                   index of the next beat to be accepted
// Pipeline: S1 product register, S2 accumulator, S3 output register. The whole pipe
// freezes while a result waits for the consumer.
module dct_mac_pipe
   import dct_mac_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned COEF_W  = DefCoefW,
   parameter int unsigned ACC_W   = DefAccW,
   parameter int unsigned N_TAPS  = DefNTaps,
   parameter int unsigned FRAC_SH = DefFracSh,
   parameter int unsigned OUT_W   = DefOutW,
   localparam int unsigned TAP_W  = tap_width(N_TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_sample,
   input  logic [COEF_W-1:0] in_coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_result,
   output logic              out_sat,
   output logic [TAP_W-1:0]  tap_idx
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;

   if (!acc_w_ok(ACC_W, DATA_W, COEF_W, N_TAPS) || N_TAPS < 2 || FRAC_SH < 1)
   begin : g_param_check
      $fatal(1, "dct_mac_pipe: illegal parameters (ACC_W too narrow or N_TAPS/FRAC_SH out of range)");
   end

   logic                     stall;
   logic                     accept;
   logic                     tap_last;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic signed [PROD_W-1:0] prod_d;
   logic                     s1_valid_q, s1_first_q, s1_last_q;
   logic signed [PROD_W-1:0] s1_prod_q;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     s2_last_q;
   logic                     s3_load;
   logic                     out_valid_q, out_sat_q;
   logic [OUT_W-1:0]         out_result_q;
   logic [OUT_W-1:0]         rs_result;
   logic                     rs_sat;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;
   // A beat presented together with clear is dropped.
   assign accept   = in_valid & in_ready & ~clear;
   assign tap_last = (tap_q == TAP_W'(N_TAPS - 1));
   // A completed group still sitting in S2 counts as in flight and is discarded by clear.
   assign s3_load  = s2_last_q & ~clear;

   always_comb begin
      tap_d = tap_q;
      if (accept) begin
         tap_d = tap_last ? '0 : tap_q + TAP_W'(1);
      end
      prod_d = PROD_W'($signed(in_sample)) * PROD_W'($signed(in_coef));
      acc_d  = (s1_first_q ? '0 : acc_q) + ACC_W'(s1_prod_q);
   end

   dct_mac_round_sat #(
      .ACC_W   (ACC_W),
      .FRAC_SH (FRAC_SH),
      .OUT_W   (OUT_W)
   ) u_round_sat (
      .acc    (acc_q),
      .result (rs_result),
      .sat    (rs_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_first_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_prod_q    <= '0;
         acc_q        <= '0;
         s2_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         if (clear) begin
            tap_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
         end else if (!stall) begin
            tap_q      <= tap_d;
            s1_valid_q <= accept;
            if (accept) begin
               s1_prod_q  <= prod_d;
               s1_first_q <= (tap_q == '0);
               s1_last_q  <= tap_last;
            end
            s2_last_q <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
               acc_q <= acc_d;
            end
         end
         // S3 is left alone by clear so a finished result is still delivered.
         if (!stall) begin
            out_valid_q <= s3_load;
            if (s3_load) begin
               out_result_q <= rs_result;
               out_sat_q    <= rs_sat;
            end
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_sat    = out_sat_q;
   assign tap_idx    = tap_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// tb_dct_mac_pipe: directed, table-driven bench for dct_mac_pipe with default parameters.
module tb_dct_mac_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_sample;
   logic [15:0] in_coef;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_result;
   logic        out_sat;
   logic [2:0]  tap_idx;

   dct_mac_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sample  (in_sample),
      .in_coef    (in_coef),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_sat    (out_sat),
      .tap_idx    (tap_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][7:0]  smp;
      logic [7:0][15:0] cof;
      logic [11:0]      res;
      logic             sat;
   } vec_t;

   typedef struct packed {
      logic [11:0] res;
      logic        sat;
   } exp_t;

   vec_t vecs [9];
   exp_t exp_q [$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   int   mon_idx = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_group(input int v);
      for (int k = 0; k < 8; k++) begin
         in_valid  = 1'b1;
         in_sample = vecs[v].smp[k];
         in_coef   = vecs[v].cof[k];
         tick();
      end
      in_valid  = 1'b0;
      in_sample = '0;
      in_coef   = '0;
   endtask

   task automatic wait_valid(input int max_cyc);
      for (int i = 0; i < max_cyc && !out_valid; i++) tick();
   endtask

   // Scoreboard for back-to-back table groups.
   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("table_unexpected_result", 32'(out_result), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("table%0d_result", mon_idx), 32'(out_result), 32'(e.res));
            check($sformatf("table%0d_sat", mon_idx), 32'(out_sat), 32'(e.sat));
            mon_idx++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          beat, got_n, hold, stall_cnt, cyc, gv, n;
      bit          first_seen, acc_b;
      logic [11:0] held, r;
      logic [11:0] got_res [2];
      logic        got_sat [2];

      // Vector table: {samples, coefficients, expected result, expected sat}.
      for (int v = 0; v < 9; v++) begin
         vecs[v].smp = '0;
         vecs[v].cof = '0;
      end
      vecs[0].smp = {8{8'h01}}; vecs[0].cof = {8{16'h4000}}; vecs[0].res = 12'd8;  vecs[0].sat = 0;
      vecs[1].smp[0] = 8'h01;   vecs[1].cof[0] = 16'h2000;   vecs[1].res = 12'd1;  vecs[1].sat = 0;
      vecs[2].smp[0] = 8'hFF;   vecs[2].cof[0] = 16'h2000;   vecs[2].res = 12'd0;  vecs[2].sat = 0;
      vecs[3].smp = {8{8'h80}}; vecs[3].cof = {8{16'h8000}}; vecs[3].res = 12'h7FF; vecs[3].sat = 1;
      vecs[4].smp = {8{8'h7F}}; vecs[4].cof = {8{16'h8000}}; vecs[4].res = 12'h810; vecs[4].sat = 0;
      vecs[5].smp = {8{8'h80}}; vecs[5].cof = {8{16'h7FFF}}; vecs[5].res = 12'h800; vecs[5].sat = 0;
      for (int k = 0; k < 8; k++) begin
         vecs[6].smp[k] = 8'(k + 1);
         vecs[6].cof[k] = (k % 2 == 1) ? 16'hC000 : 16'h4000;
      end
      vecs[6].res = 12'hFFC; vecs[6].sat = 0;
      vecs[7].smp[0] = 8'h03;   vecs[7].cof[0] = 16'h2000;   vecs[7].res = 12'd2;  vecs[7].sat = 0;
      vecs[8].smp[0] = 8'hFD;   vecs[8].cof[0] = 16'h2000;   vecs[8].res = 12'hFFF; vecs[8].sat = 0;

      // Reset state.
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sample = '0; in_coef = '0; out_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_in_ready", 32'(in_ready), 1);
      check("reset_tap_idx", 32'(tap_idx), 0);
      check("reset_out_result", 32'(out_result), 0);
      check("reset_out_sat", 32'(out_sat), 0);
      rst = 1'b0;
      tick();

      // Unity gain with exact latency and tap counter.
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_sample = 8'h01; in_coef = 16'h4000;
         tick();
         if (k == 2) check("tap_idx_after3", 32'(tap_idx), 3);
      end
      in_valid = 1'b0;
      check("tap_idx_wrap", 32'(tap_idx), 0);
      @(negedge clk);
      check("latency_t1_valid", 32'(out_valid), 0);
      tick();
      @(negedge clk);
      check("latency_t2_valid", 32'(out_valid), 0);
      tick();
      @(negedge clk);
      check("latency_t3_valid", 32'(out_valid), 1);
      check("unity_result", 32'(out_result), 8);
      check("unity_sat", 32'(out_sat), 0);
      tick();
      check("valid_drop_after_accept", 32'(out_valid), 0);

      // Table groups back to back, no idle beat between groups.
      for (int v = 0; v < 9; v++) exp_q.push_back('{res: vecs[v].res, sat: vecs[v].sat});
      mon_en = 1'b1;
      for (int v = 0; v < 9; v++) drive_group(v);
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
      check("table_drained", 32'(exp_q.size()), 0);
      mon_en = 1'b0;

      // Backpressure: two groups, consumer stalls 5 cycles on the first result.
      beat = 0; got_n = 0; hold = 0; stall_cnt = 0; cyc = 0; first_seen = 0; held = '0;
      while (got_n < 2 && cyc < 80) begin
         gv = (beat < 8) ? 0 : 6;
         in_valid = (beat < 16);
         if (beat < 16) begin
            in_sample = vecs[gv].smp[beat % 8];
            in_coef   = vecs[gv].cof[beat % 8];
         end
         if (out_valid && !first_seen) begin
            first_seen = 1; hold = 5; held = out_result;
         end
         out_ready = (hold == 0);
         @(negedge clk);
         if (!in_ready) stall_cnt++;
         if (hold > 0) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_result", 32'(out_result), 32'(held));
         end
         if (out_valid && out_ready) begin
            if (got_n < 2) begin
               got_res[got_n] = out_result;
               got_sat[got_n] = out_sat;
            end
            got_n++;
         end
         acc_b = in_valid && in_ready;
         tick();
         if (acc_b) beat++;
         if (hold > 0) hold--;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_results_seen", 32'(got_n), 2);
      check("bp_stall_cycles", 32'(stall_cnt), 5);
      check("bp_beats_accepted", 32'(beat), 16);
      if (got_n == 2) begin
         check("bp_first_result", 32'(got_res[0]), 8);
         check("bp_first_sat", 32'(got_sat[0]), 0);
         check("bp_second_result", 32'(got_res[1]), 32'h0000_0FFC);
         check("bp_second_sat", 32'(got_sat[1]), 0);
      end
      tick();

      // Abort a partial group, then a full unity group yields exactly one result.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_sample = 8'h01; in_coef = 16'h4000;
         tick();
      end
      clear = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      check("clear_tap_idx", 32'(tap_idx), 0);
      drive_group(0);
      n = 0; r = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            n++;
            r = out_result;
         end
         tick();
      end
      check("clear_result_count", 32'(n), 1);
      check("clear_result", 32'(r), 8);

      // Clear while a result is pending in S3: it must survive.
      out_ready = 1'b0;
      drive_group(0);
      wait_valid(8);
      check("pend_valid", 32'(out_valid), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      check("pend_kept_valid", 32'(out_valid), 1);
      check("pend_kept_result", 32'(out_result), 8);
      out_ready = 1'b1;
      tick();
      check("pend_consumed", 32'(out_valid), 0);

      // Reset while stalled on a result.
      out_ready = 1'b0;
      drive_group(3);
      wait_valid(8);
      check("rst_stall_pending", 32'(out_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall_valid", 32'(out_valid), 0);
      check("rst_stall_tap_idx", 32'(tap_idx), 0);
      check("rst_stall_in_ready", 32'(in_ready), 1);
      check("rst_stall_result", 32'(out_result), 0);
      out_ready = 1'b1;
      tick();
      drive_group(4);
      wait_valid(6);
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 1);
      check("post_rst_result", 32'(out_result), 32'h0000_0810);
      check("post_rst_sat", 32'(out_sat), 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dct_mac_pipe.md
Name: dct_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit for the forward-DCT datapath of the JPEG encoder. It is the successor to the fixed-width macu.
- Accepts one signed sample/coefficient pair per beat and accumulates exactly N_TAPS products.
- Emits one rounded, saturated result per N_TAPS-beat group over a valid/ready output with backpressure.
- Sits inside each dct_unit, between the sample/coefficient sequencer and the zigzag/quantiser stage.

Parameters:
DATA_W, 8, signed sample width (level-shifted pixel)
COEF_W, 16, signed coefficient width (Q1.(COEF_W-2) format, 1.0 = 2^FRAC_SH)
ACC_W, 32, signed accumulator width; must be >= DATA_W+COEF_W+clog2(N_TAPS)
N_TAPS, 8, products per result (>= 2)
FRAC_SH, 14, right shift applied to the accumulator before output (>= 1)
OUT_W, 12, signed result width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  sync abort: discard partial group and in-flight products
in_valid  in  1  sample/coef beat valid
in_ready  out  1  unit can accept a beat
in_sample  in  DATA_W  signed sample
in_coef  in  COEF_W  signed coefficient
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  OUT_W  rounded, saturated signed result
out_sat  out  1  result was clipped
tap_idx  out  clog2(N_TAPS)  index of the next beat to be accepted (debug/sequencer sync)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_sat=0, tap_idx=0, accumulator=0, all stage valids=0.
- Handshake and stall:
  - A beat transfers when in_valid & in_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - During stall every pipeline register holds. No beat is lost or duplicated.
  - out_result and out_sat hold stable while out_valid & ~out_ready.
- Pipeline, all advancing when ~stall:
  - S1: product register p = in_sample * in_coef, signed full width DATA_W+COEF_W. Carries a valid bit and a last flag (tap_idx==N_TAPS-1).
  - S2: accumulator. If S1 valid: acc = (first ? 0 : acc) + sext(p), with first = S1 tap 0.
  - S3: output register. Loaded when S2 completes the last tap:
    - r = (acc + 2^(FRAC_SH-1)) >>> FRAC_SH (round half up, arithmetic shift).
    - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clipped.
- Latency: the last beat accepted in cycle t gives out_valid high in cycle t+3.
  - Sustained throughput is one beat/cycle with out_ready held high.
  - A new group may start the cycle after the previous group's last beat, with no bubble.
- out_valid clear: out_valid drops when accepted unless a new result loads the same cycle. In that case it stays high with the new data.
- tap_idx: increments on each accepted beat and wraps from N_TAPS-1 to 0.
- clear:
  - Next cycle: tap_idx=0, acc=0, S1/S2 valids=0.
  - A beat presented with clear is dropped.
  - An already-valid S3 result is kept and still delivered.
- rst mid-group or mid-stall: every register returns to its reset value; the pending result is lost.
- Accumulator overflow: cannot occur under the ACC_W rule. An elaboration-time assertion checks it.

Decomposition:
- Package dct_mac_pkg: width-check function, sat/round helper function, clog2 localparams.
- One natural sub-module: dct_mac_round_sat (combinational acc -> result/sat), reused by the IDCT path later.
- Counter, pipeline and handshake stay in dct_mac_pipe.

Test Plan:
- Unity gain: 8 beats, sample=1, coef=16384, out_ready=1 -> out_result=8, out_sat=0, out_valid exactly 3 cycles after the 8th beat.
- Rounding: beat0 sample=1, coef=8192, beats1-7 zero -> result 1. Beat0 sample=-1, coef=8192 -> result 0 (half rounds up).
- Saturation: 8 beats sample=-128, coef=-32768 -> acc=33554432 -> out_result=2047, out_sat=1. Sample=127, coef=-32768 -> -2032, out_sat=0.
- Backpressure: two back-to-back groups with out_ready low for 5 cycles after the first result -> in_ready low 5 cycles, first result held stable, both results correct and in order, no beat dropped.
- Abort: clear after beat 4 of a group, then a full unity group -> single result 8 (partial discarded). Clear asserted with a pending S3 result -> that result is still delivered.
- Reset mid-stall: rst while out_valid=1, out_ready=0 -> next cycle out_valid=0, tap_idx=0, in_ready=1. The following group produces the correct result.
